// File: rtl/sincos_iter.sv
// Iterative sine/cosine in signed fixed point. One shared multiplier; the angle is folded into
// [-pi/2, pi/2] and an odd Taylor polynomial is evaluated by Horner's rule, one product per cycle.
module sincos_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned TERMS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_angle,
    input  logic             in_cos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_err
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam real         Scale = 2.0 ** FRAC;
    localparam real         PiR   = 3.14159265358979323846;

    // Real-to-integer casts round to nearest, giving the fixed-point constants.
    localparam logic signed [WIDTH-1:0] Pi     = WIDTH'(longint'(PiR * Scale));
    localparam logic signed [WIDTH-1:0] HalfPi = WIDTH'(longint'(PiR * Scale / 2.0));
    localparam logic signed [WIDTH-1:0] TwoPi  = WIDTH'(longint'(2.0 * PiR * Scale));
    localparam logic signed [WIDTH-1:0] Zero   = '0;
    localparam logic signed [WIDTH-1:0] One    = WIDTH'(longint'(Scale));
    localparam logic signed [WIDTH-1:0] C0     = One;
    localparam logic signed [WIDTH-1:0] C1     = WIDTH'(longint'(-Scale / 6.0));
    localparam logic signed [WIDTH-1:0] C2     = WIDTH'(longint'(Scale / 120.0));
    localparam logic signed [WIDTH-1:0] C3     = WIDTH'(longint'(-Scale / 5040.0));

    typedef enum logic [2:0] {
        StIdle,
        StReduce,
        StSquare,
        StHorner,
        StFinal,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic signed [WIDTH-1:0]   x_q, x_d;
    logic signed [WIDTH-1:0]   x2_q, x2_d;
    logic signed [WIDTH-1:0]   acc_q, acc_d;
    logic [1:0]                k_q, k_d;
    logic                      err_q, err_d;
    logic signed [WIDTH-1:0]   out_value_q, out_value_d;
    logic                      out_err_q, out_err_d;

    logic signed [WIDTH-1:0]   x_wrap;
    logic signed [WIDTH-1:0]   x_fold;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    logic signed [PW-1:0]      prod;
    logic signed [WIDTH-1:0]   mul_res;
    logic signed [WIDTH-1:0]   res_clamped;
    logic signed [WIDTH-1:0]   angle_s;

    // Taylor coefficient for the odd power 2k+1.
    function automatic logic signed [WIDTH-1:0] coef(input logic [1:0] k);
        case (k)
            2'd0:    coef = C0;
            2'd1:    coef = C1;
            2'd2:    coef = C2;
            default: coef = C3;
        endcase
    endfunction

    assign angle_s = $signed(in_angle);

    // Range reduction: wrap into [-pi, pi], then mirror about +-pi/2 (strict compares).
    always_comb begin
        x_wrap = x_q;
        if (x_q > Pi) begin
            x_wrap = x_q - TwoPi;
        end else if (x_q < -Pi) begin
            x_wrap = x_q + TwoPi;
        end
        x_fold = x_wrap;
        if (x_wrap > HalfPi) begin
            x_fold = Pi - x_wrap;
        end else if (x_wrap < -HalfPi) begin
            x_fold = -Pi - x_wrap;
        end
    end

    // Operand steering for the single shared multiplier.
    always_comb begin
        mul_a = acc_q;
        mul_b = x2_q;
        case (state_q)
            StSquare: begin
                mul_a = x_q;
                mul_b = x_q;
            end
            StFinal: begin
                mul_a = acc_q;
                mul_b = x_q;
            end
            default: begin
                mul_a = acc_q;
                mul_b = x2_q;
            end
        endcase
    end

    // Full-width signed product, rescaled by FRAC and truncated back to WIDTH.
    always_comb begin
        prod    = PW'(mul_a) * PW'(mul_b);
        mul_res = WIDTH'(prod >>> FRAC);
    end

    // Clamp catches polynomial overshoot just below +-pi/2.
    always_comb begin
        res_clamped = mul_res;
        if (mul_res > One) begin
            res_clamped = One;
        end else if (mul_res < -One) begin
            res_clamped = -One;
        end
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        x2_d        = x2_q;
        acc_d       = acc_q;
        k_d         = k_q;
        err_d       = err_q;
        out_value_d = out_value_q;
        out_err_d   = out_err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // cos(a) = sin(a + pi/2)
                    x_d     = angle_s + (in_cos ? HalfPi : Zero);
                    err_d   = (angle_s > TwoPi) || (angle_s < -TwoPi);
                    state_d = StReduce;
                end
            end
            StReduce: begin
                x_d     = x_fold;
                state_d = StSquare;
            end
            StSquare: begin
                x2_d    = mul_res;
                acc_d   = coef(2'(TERMS - 1));
                k_d     = 2'(TERMS - 2);
                state_d = StHorner;
            end
            StHorner: begin
                acc_d = coef(k_q) + mul_res;
                if (k_q == 2'd0) begin
                    state_d = StFinal;
                end else begin
                    k_d = k_q - 2'd1;
                end
            end
            StFinal: begin
                // Out-of-range operands run the same sequence; their result is dropped here.
                out_value_d = err_q ? Zero : res_clamped;
                out_err_d   = err_q;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            x2_q        <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            err_q       <= 1'b0;
            out_value_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            x2_q        <= x2_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            err_q       <= err_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_value = out_value_q;
    assign out_err   = out_err_q;

endmodule
